apb_regfile_slave: RTL and testbench
====================================

// Module: apb_regfile_slave
// PURPOSE
//  Parametrised APB slave: DEPTH x DATA_W register file with a programmable wait-state
//  count, byte strobes and PSLVERR on illegal access. Generates PREADY internally from
//  the protocol phase. No testbench-side PREADY shaping is needed.
//  Attaches to apb_master and apb_bus_monitor on the shared APB bus.
// PARAMETERS
//  ADDR_W   32  PADDR width (bits)
//  DATA_W   32  PWDATA/PRDATA width; must be 8, 16 or 32
//  DEPTH    16  number of registers; power of two, >= 2
//  WAIT_W   4   width of wait_cycles; max wait = 2**WAIT_W-1
// PORTS
//  PCLK         in   1          APB clock, all logic on rising edge
//  PRESETn      in   1          asynchronous, active-low reset
//  PSEL         in   1          slave select
//  PENABLE      in   1          access phase
//  PWRITE       in   1          1=write, 0=read
//  PADDR        in   ADDR_W     byte address
//  PWDATA       in   DATA_W     write data
//  PSTRB        in   DATA_W/8   write byte strobes; ignored on reads
//  PRDATA       out  DATA_W     read data, valid only while PREADY=1 on a read
//  PREADY       out  1          transfer complete (registered)
//  PSLVERR      out  1          error, valid only while PREADY=1
//  wait_cycles  in   WAIT_W     wait states to insert; sampled in setup phase
// BEHAVIOUR
//  Reset: PREADY=0, PSLVERR=0, PRDATA=0, state=IDLE, counter=0, all registers=0.
//   Reset asserted mid-transfer aborts it; no write is committed.
//  FSM states:
//   IDLE -> WAIT when PSEL=1 and PENABLE=0 (setup). At this edge:
//    counter loaded from wait_cycles; address and write flag latched.
//    If wait_cycles=0, PREADY is set at this same edge and state goes to DONE.
//   WAIT: counter decrements each cycle. When counter reaches 1, the next edge sets
//    PREADY=1 -> DONE. Result: PREADY=1 in access cycle wait_cycles+1.
//   DONE: PREADY=1 for exactly one cycle; the edge ending it returns to IDLE, PREADY=0.
//  Protocol violation: PSEL=0 in WAIT/DONE -> IDLE, PREADY=0, no write, no error.
//  Address: idx = PADDR[log2(DEPTH)+A-1 : A], where A = log2(DATA_W/8).
//  Error (PSLVERR=1 with PREADY): PADDR low A bits != 0, or PADDR >= DEPTH*(DATA_W/8).
//   Erroneous writes are dropped; erroneous reads return PRDATA=0.
//  Write commit: at the DONE edge (PSEL&PENABLE&PREADY&PWRITE, no error).
//   Only bytes with PSTRB[i]=1 are updated. PSTRB=0 is a legal no-op, no error.
//  Read data: registered into PRDATA at the edge that sets PREADY.
//   PRDATA returns to 0 when PREADY drops, and is 0 on writes.
//  Back-to-back: a new setup may occur in the cycle after DONE.
//   A write then read to the same idx returns the new data.
//  PWDATA, PSTRB and PADDR are taken from the DONE cycle / latched value;
//   the master holds them stable per APB.
// STRUCTURE
//  apb_pkg: state enum {IDLE,WAIT,DONE}; function clog2; localparam STRB_W=DATA_W/8.
//  Sub-module apb_wait_ctr: load/decrement counter with zero flag, WAIT_W wide.
//  Register array and strobe merge are inline.
// TESTING
//  1 wait_cycles=0, write 0x0000<-0x5678 strobes 0xF -> PREADY in 1st access cycle;
//    read 0x0000 -> PRDATA=0x5678, PSLVERR=0.
//  2 wait_cycles=3, write 0x0004<-0xDEADBEEF -> PREADY low for 3 access cycles,
//    high on the 4th; readback matches.
//  3 0x0008=0x11223344, write 0xAABBCCDD with PSTRB=4'b0101 -> readback 0x11BB33DD.
//  4 read 0x0040 (DEPTH=16) and write 0x0002 -> PSLVERR=1 with PREADY, PRDATA=0,
//    memory unchanged.
//  5 PRESETn low during WAIT of write to 0x000C -> outputs 0 at once; after release,
//    read 0x000C = 0.
//  6 PSEL dropped in WAIT -> FSM in IDLE next cycle, PREADY never asserts, no write.

Source files
------------

// File: rtl/apb_pkg.sv
// Shared types and helpers for the APB register-file slave.
package apb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DONE = 2'd2
    } apb_state_e;

    localparam int BYTE_W = 8;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) r = i + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/apb_wait_ctr.sv
// Wait-state counter: load, clear, or decrement toward zero; flags zero and last.
module apb_wait_ctr #(
    parameter int WAIT_W = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_clr,
    input  logic              i_load,
    input  logic [WAIT_W-1:0] i_load_val,
    input  logic              i_dec,
    output logic              o_zero,
    output logic              o_last
);

    logic [WAIT_W-1:0] r_count;

    // NOTE: sequential state uses <= so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
        end else if (i_clr) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= i_load_val;
        end else if (i_dec && (r_count != '0)) begin
            r_count <= r_count - WAIT_W'(1);
        end
    end

    assign o_zero = (r_count == '0);
    assign o_last = (r_count == WAIT_W'(1));

endmodule

// File: rtl/apb_regfile_slave.sv
// APB slave with a DEPTH x DATA_W register file, programmable wait states,
// byte strobes and PSLVERR on misaligned or out-of-range accesses.
module apb_regfile_slave
    import apb_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int DEPTH  = 16,
    parameter int WAIT_W = 4
) (
    input  logic                     PCLK,
    input  logic                     PRESETn,
    input  logic                     PSEL,
    input  logic                     PENABLE,
    input  logic                     PWRITE,
    input  logic [ADDR_W-1:0]        PADDR,
    input  logic [DATA_W-1:0]        PWDATA,
    input  logic [DATA_W/BYTE_W-1:0] PSTRB,
    output logic [DATA_W-1:0]        PRDATA,
    output logic                     PREADY,
    output logic                     PSLVERR,
    input  logic [WAIT_W-1:0]        wait_cycles
);

    localparam int STRB_W = DATA_W / BYTE_W;
    localparam int A_W    = clog2(STRB_W);
    localparam int IDX_W  = clog2(DEPTH);
    localparam logic [ADDR_W-1:0] ALIGN_MASK = ADDR_W'(STRB_W - 1);

    apb_state_e r_state, w_next_state;

    logic [ADDR_W-1:0] r_addr;
    logic              r_write;
    logic              r_pready;
    logic              r_pslverr;
    logic [DATA_W-1:0] r_prdata;
    logic [DATA_W-1:0] r_mem [DEPTH];

    logic              w_load, w_dec, w_clr, w_fire, w_commit;
    logic              w_ctr_zero, w_ctr_last;
    logic [ADDR_W-1:0] w_addr;
    logic              w_wr;
    logic              w_err;
    logic [IDX_W-1:0]  w_idx;

    apb_wait_ctr #(.WAIT_W(WAIT_W)) u_wait_ctr (
        .clk        (PCLK),
        .rst_n      (PRESETn),
        .i_clr      (w_clr),
        .i_load     (w_load),
        .i_load_val (wait_cycles),
        .i_dec      (w_dec),
        .o_zero     (w_ctr_zero),
        .o_last     (w_ctr_last)
    );

    // In IDLE the live bus is decoded so a zero-wait access can complete at the setup edge.
    assign w_addr = (r_state == IDLE) ? PADDR  : r_addr;
    assign w_wr   = (r_state == IDLE) ? PWRITE : r_write;
    assign w_idx  = w_addr[IDX_W+A_W-1:A_W];
    assign w_err  = (|(w_addr & ALIGN_MASK)) || ((w_addr >> (IDX_W + A_W)) != '0);

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) r_state <= IDLE;
        else          r_state <= w_next_state;
    end

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        w_next_state = r_state;
        w_load       = 1'b0;
        w_dec        = 1'b0;
        w_clr        = 1'b0;
        w_fire       = 1'b0;
        w_commit     = 1'b0;
        unique case (r_state)
            IDLE: begin
                if (PSEL && !PENABLE) begin
                    w_load = 1'b1;
                    if (wait_cycles == '0) begin
                        w_fire       = 1'b1;
                        w_next_state = DONE;
                    end else begin
                        w_next_state = WAIT;
                    end
                end
            end
            WAIT: begin
                if (!PSEL) begin
                    w_clr        = 1'b1;
                    w_next_state = IDLE;
                end else begin
                    w_dec = 1'b1;
                    if (w_ctr_last || w_ctr_zero) begin
                        w_fire       = 1'b1;
                        w_next_state = DONE;
                    end
                end
            end
            DONE: begin
                w_next_state = IDLE;
                w_commit     = PSEL && PENABLE && PWRITE && r_pready && !r_pslverr;
            end
            default: w_next_state = IDLE;
        endcase
    end

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            r_addr    <= '0;
            r_write   <= 1'b0;
            r_pready  <= 1'b0;
            r_pslverr <= 1'b0;
            r_prdata  <= '0;
        end else begin
            if (w_load) begin
                r_addr  <= PADDR;
                r_write <= PWRITE;
            end
            r_pready  <= w_fire;
            r_pslverr <= w_fire && w_err;
            r_prdata  <= (w_fire && !w_wr && !w_err) ? r_mem[w_idx] : '0;
        end
    end

    // NOTE: the register file is reset because software expects all registers to read 0.
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
        end else if (w_commit) begin
            for (int b = 0; b < STRB_W; b++) begin
                if (PSTRB[b]) r_mem[w_idx][b*BYTE_W +: BYTE_W] <= PWDATA[b*BYTE_W +: BYTE_W];
            end
        end
    end

    assign PREADY  = r_pready;
    assign PSLVERR = r_pslverr;
    assign PRDATA  = r_prdata;

endmodule

// File: tb/tb_apb_regfile_slave.sv
// Directed self-checking bench for apb_regfile_slave (default parameters).
module tb_apb_regfile_slave;

    logic        PCLK = 1'b0;
    logic        PRESETn;
    logic        PSEL, PENABLE, PWRITE;
    logic [31:0] PADDR, PWDATA, PRDATA;
    logic [3:0]  PSTRB, wait_cycles;
    logic        PREADY, PSLVERR;

    int checks = 0;
    int errors = 0;

    apb_regfile_slave dut (
        .PCLK        (PCLK),
        .PRESETn     (PRESETn),
        .PSEL        (PSEL),
        .PENABLE     (PENABLE),
        .PWRITE      (PWRITE),
        .PADDR       (PADDR),
        .PWDATA      (PWDATA),
        .PSTRB       (PSTRB),
        .PRDATA      (PRDATA),
        .PREADY      (PREADY),
        .PSLVERR     (PSLVERR),
        .wait_cycles (wait_cycles)
    );

    always #5 PCLK = ~PCLK;

    // Entered 1 time unit after a rising edge; returns 1 time unit after the edge ending DONE.
    task automatic apb_xfer(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                            input logic [3:0] strb, input logic [3:0] wc,
                            output logic [31:0] rdata, output logic slverr,
                            output int ready_cyc, output logic ready_after);
        PSEL = 1'b1; PENABLE = 1'b0; PWRITE = wr; PADDR = addr;
        PWDATA = wdata; PSTRB = strb; wait_cycles = wc;
        @(posedge PCLK); #1;
        PENABLE = 1'b1;
        ready_cyc = -1; rdata = 'x; slverr = 1'bx; ready_after = 1'bx;
        for (int c = 1; c <= 40; c++) begin
            if (PREADY === 1'b1) begin
                ready_cyc = c; rdata = PRDATA; slverr = PSLVERR;
                break;
            end
            @(posedge PCLK); #1;
        end
        if (ready_cyc > 0) begin
            @(posedge PCLK); #1;
            ready_after = PREADY;
        end
        PSEL = 1'b0; PENABLE = 1'b0;
    endtask

    task automatic test_reset();
        logic [31:0] rd; logic err; int cyc; logic aft;
        PRESETn = 1'b1; PSEL = 0; PENABLE = 0; PWRITE = 0;
        PADDR = '0; PWDATA = '0; PSTRB = '0; wait_cycles = '0;
        #1 PRESETn = 1'b0;
        #12;
        checks++; if (PREADY !== 1'b0) begin errors++; $display("FAIL reset_pready: got %b exp 0", PREADY); end
        checks++; if (PSLVERR !== 1'b0) begin errors++; $display("FAIL reset_pslverr: got %b exp 0", PSLVERR); end
        checks++; if (PRDATA !== 32'h0) begin errors++; $display("FAIL reset_prdata: got %h exp 0", PRDATA); end
        @(posedge PCLK); #1 PRESETn = 1'b1;
        @(posedge PCLK); #1;
        apb_xfer(1'b0, 32'h3C, 32'h0, 4'h0, 4'd0, rd, err, cyc, aft);
        checks++; if (rd !== 32'h0) begin errors++; $display("FAIL reset_mem_3c: got %h exp 0", rd); end
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL reset_read_err: got %b exp 0", err); end
    endtask

    task automatic test_zero_wait();
        logic [31:0] rd; logic err; int cyc; logic aft;
        apb_xfer(1'b1, 32'h0, 32'h5678, 4'hF, 4'd0, rd, err, cyc, aft);
        checks++; if (cyc !== 1) begin errors++; $display("FAIL zw_write_cycle: got %0d exp 1", cyc); end
        checks++; if (rd !== 32'h0) begin errors++; $display("FAIL zw_write_prdata: got %h exp 0", rd); end
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL zw_write_err: got %b exp 0", err); end
        checks++; if (aft !== 1'b0) begin errors++; $display("FAIL zw_write_ready_drop: got %b exp 0", aft); end
        apb_xfer(1'b0, 32'h0, 32'h0, 4'h0, 4'd0, rd, err, cyc, aft);
        checks++; if (cyc !== 1) begin errors++; $display("FAIL zw_read_cycle: got %0d exp 1", cyc); end
        checks++; if (rd !== 32'h5678) begin errors++; $display("FAIL zw_read_data: got %h exp 5678", rd); end
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL zw_read_err: got %b exp 0", err); end
        checks++; if (PRDATA !== 32'h0) begin errors++; $display("FAIL zw_prdata_drop: got %h exp 0", PRDATA); end
    endtask

    task automatic test_wait_states();
        logic [31:0] rd; logic err; int cyc; logic aft;
        apb_xfer(1'b1, 32'h4, 32'hDEADBEEF, 4'hF, 4'd3, rd, err, cyc, aft);
        checks++; if (cyc !== 4) begin errors++; $display("FAIL ws_write_cycle: got %0d exp 4", cyc); end
        checks++; if (aft !== 1'b0) begin errors++; $display("FAIL ws_ready_one_cycle: got %b exp 0", aft); end
        apb_xfer(1'b0, 32'h4, 32'h0, 4'h0, 4'd3, rd, err, cyc, aft);
        checks++; if (cyc !== 4) begin errors++; $display("FAIL ws_read_cycle: got %0d exp 4", cyc); end
        checks++; if (rd !== 32'hDEADBEEF) begin errors++; $display("FAIL ws_read_data: got %h exp deadbeef", rd); end
    endtask

    task automatic test_strobes();
        logic [31:0] rd; logic err; int cyc; logic aft;
        apb_xfer(1'b1, 32'h8, 32'h11223344, 4'hF, 4'd1, rd, err, cyc, aft);
        checks++; if (cyc !== 2) begin errors++; $display("FAIL strb_init_cycle: got %0d exp 2", cyc); end
        apb_xfer(1'b1, 32'h8, 32'hAABBCCDD, 4'b0101, 4'd0, rd, err, cyc, aft);
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL strb_partial_err: got %b exp 0", err); end
        apb_xfer(1'b1, 32'h8, 32'hFFFFFFFF, 4'b0000, 4'd2, rd, err, cyc, aft);
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL strb_none_err: got %b exp 0", err); end
        checks++; if (cyc !== 3) begin errors++; $display("FAIL strb_none_cycle: got %0d exp 3", cyc); end
        apb_xfer(1'b0, 32'h8, 32'h0, 4'h0, 4'd0, rd, err, cyc, aft);
        checks++; if (rd !== 32'h11BB33DD) begin errors++; $display("FAIL strb_readback: got %h exp 11bb33dd", rd); end
    endtask

    task automatic test_errors();
        logic [31:0] rd; logic err; int cyc; logic aft;
        apb_xfer(1'b0, 32'h40, 32'h0, 4'h0, 4'd2, rd, err, cyc, aft);
        checks++; if (cyc !== 3) begin errors++; $display("FAIL err_oor_cycle: got %0d exp 3", cyc); end
        checks++; if (err !== 1'b1) begin errors++; $display("FAIL err_oor_slverr: got %b exp 1", err); end
        checks++; if (rd !== 32'h0) begin errors++; $display("FAIL err_oor_prdata: got %h exp 0", rd); end
        checks++; if (aft !== 1'b0) begin errors++; $display("FAIL err_oor_ready_drop: got %b exp 0", aft); end
        checks++; if (PSLVERR !== 1'b0) begin errors++; $display("FAIL err_slverr_drop: got %b exp 0", PSLVERR); end
        apb_xfer(1'b1, 32'h2, 32'hFFFFFFFF, 4'hF, 4'd0, rd, err, cyc, aft);
        checks++; if (err !== 1'b1) begin errors++; $display("FAIL err_misalign_slverr: got %b exp 1", err); end
        checks++; if (cyc !== 1) begin errors++; $display("FAIL err_misalign_cycle: got %0d exp 1", cyc); end
        apb_xfer(1'b0, 32'h0, 32'h0, 4'h0, 4'd0, rd, err, cyc, aft);
        checks++; if (rd !== 32'h5678) begin errors++; $display("FAIL err_mem_unchanged: got %h exp 5678", rd); end
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL err_legal_read: got %b exp 0", err); end
        apb_xfer(1'b0, 32'h3C, 32'h0, 4'h0, 4'd0, rd, err, cyc, aft);
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL err_last_idx: got %b exp 0", err); end
    endtask

    task automatic test_psel_drop();
        logic [31:0] rd; logic err; int cyc; logic aft;
        PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1; PADDR = 32'h10;
        PWDATA = 32'h0BADF00D; PSTRB = 4'hF; wait_cycles = 4'd3;
        @(posedge PCLK); #1 PENABLE = 1'b1;
        @(posedge PCLK); #1 PSEL = 1'b0; PENABLE = 1'b0;
        checks++; if (PREADY !== 1'b0) begin errors++; $display("FAIL drop_ready_access: got %b exp 0", PREADY); end
        @(posedge PCLK); #1;
        checks++; if (PREADY !== 1'b0) begin errors++; $display("FAIL drop_ready_after: got %b exp 0", PREADY); end
        apb_xfer(1'b0, 32'h10, 32'h0, 4'h0, 4'd0, rd, err, cyc, aft);
        checks++; if (cyc !== 1) begin errors++; $display("FAIL drop_idle_restart: got %0d exp 1", cyc); end
        checks++; if (rd !== 32'h0) begin errors++; $display("FAIL drop_no_write: got %h exp 0", rd); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] rd; logic err; int cyc; logic aft;
        apb_xfer(1'b1, 32'h14, 32'hCAFEF00D, 4'hF, 4'd0, rd, err, cyc, aft);
        apb_xfer(1'b0, 32'h14, 32'h0, 4'h0, 4'd0, rd, err, cyc, aft);
        checks++; if (cyc !== 1) begin errors++; $display("FAIL b2b_read_cycle: got %0d exp 1", cyc); end
        checks++; if (rd !== 32'hCAFEF00D) begin errors++; $display("FAIL b2b_read_data: got %h exp cafef00d", rd); end
        apb_xfer(1'b1, 32'h3C, 32'hA5A5A5A5, 4'hF, 4'd2, rd, err, cyc, aft);
        apb_xfer(1'b0, 32'h3C, 32'h0, 4'h0, 4'd15, rd, err, cyc, aft);
        checks++; if (cyc !== 16) begin errors++; $display("FAIL b2b_maxwait_cycle: got %0d exp 16", cyc); end
        checks++; if (rd !== 32'hA5A5A5A5) begin errors++; $display("FAIL b2b_last_idx_data: got %h exp a5a5a5a5", rd); end
    endtask

    task automatic test_reset_mid();
        logic [31:0] rd; logic err; int cyc; logic aft;
        PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1; PADDR = 32'hC;
        PWDATA = 32'h12345678; PSTRB = 4'hF; wait_cycles = 4'd5;
        @(posedge PCLK); #1 PENABLE = 1'b1;
        @(posedge PCLK); #1;
        @(posedge PCLK); #1 PRESETn = 1'b0;
        #1;
        checks++; if (PREADY !== 1'b0) begin errors++; $display("FAIL rst_wait_ready: got %b exp 0", PREADY); end
        checks++; if (PRDATA !== 32'h0) begin errors++; $display("FAIL rst_wait_prdata: got %h exp 0", PRDATA); end
        PSEL = 1'b0; PENABLE = 1'b0;
        @(posedge PCLK); #1 PRESETn = 1'b1;
        @(posedge PCLK); #1;
        apb_xfer(1'b0, 32'hC, 32'h0, 4'h0, 4'd0, rd, err, cyc, aft);
        checks++; if (rd !== 32'h0) begin errors++; $display("FAIL rst_no_commit: got %h exp 0", rd); end
        apb_xfer(1'b1, 32'h0, 32'h00C0FFEE, 4'hF, 4'd0, rd, err, cyc, aft);
        PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b0; PADDR = 32'h0; wait_cycles = 4'd0;
        @(posedge PCLK); #1 PENABLE = 1'b1;
        checks++; if (PRDATA !== 32'h00C0FFEE) begin errors++; $display("FAIL rst_done_pre_data: got %h exp 00c0ffee", PRDATA); end
        PRESETn = 1'b0;
        #1;
        checks++; if (PREADY !== 1'b0) begin errors++; $display("FAIL rst_done_ready: got %b exp 0", PREADY); end
        checks++; if (PRDATA !== 32'h0) begin errors++; $display("FAIL rst_done_prdata: got %h exp 0", PRDATA); end
        PSEL = 1'b0; PENABLE = 1'b0;
        @(posedge PCLK); #1 PRESETn = 1'b1;
        @(posedge PCLK); #1;
        apb_xfer(1'b0, 32'h4, 32'h0, 4'h0, 4'd1, rd, err, cyc, aft);
        checks++; if (rd !== 32'h0) begin errors++; $display("FAIL rst_mem_cleared: got %h exp 0", rd); end
    endtask

    initial begin
        test_reset();
        test_zero_wait();
        test_wait_states();
        test_strobes();
        test_errors();
        test_psel_drop();
        test_back_to_back();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
